cache_inv_ctrl: RTL and testbench
=================================

# cache_inv_ctrl

Cache invalidation sequencer sitting directly downstream of the AXI-lite config register file. It consumes the decoded CONFIG_REG0/CONFIG_REG1 fields, executes full-cache or single-line (smart) invalidates against the cache tag array, and produces the 32-bit value the register file exposes as STATUS_REG_CACHE. It also returns a one-cycle pulse that tells the register file to self-clear the INVALIDATE bit.

## Interface
- ADDR_W, 32, address width; tag entries store a full line address of ADDR_W bits.
- IDX_W, 10, tag array index width; matches the 10-bit CACHE_SIZE field.

- aclk  in  1  clock; all logic on posedge.
- aresetn  in  1  reset; synchronous, active-low.
- cfg_enable  in  1  CONFIG_REG_CACHE_ENABLE.
- cfg_cache_size  in  10  number of cache lines; must be a power of two and nonzero.
- cfg_line_size  in  10  line size in bytes; must be a power of two and nonzero.
- cfg_invalidate  in  1  CONFIG_REG_CACHE_INVALIDATE level.
- cfg_smart_addr  in  ADDR_W  CONFIG_REG_CACHE_SMART_INVALIDATE.
- cfg_smart_wr  in  1  one-cycle pulse; CONFIG_REG1 was written.
- inv_clear  out  1  one-cycle pulse; register file clears INVALIDATE.
- tag_en  out  1  tag array access strobe.
- tag_we  out  1  tag write; the written entry is always valid=0.
- tag_idx  out  IDX_W  tag array index.
- tag_rvalid  in  1  valid bit of the entry read; returned 1 cycle after tag_en with tag_we=0.
- tag_rtag  in  ADDR_W  stored line address; same latency as tag_rvalid.
- status  out  32  STATUS_REG_CACHE value.
- busy  out  1  equals status[0].

## Operation
- Full request: rising edge of cfg_invalidate, detected against a registered copy.
- Smart request: cfg_smart_wr=1.
- Request checks:
  - A request made while cfg_enable=0 is ignored. A full request still pulses inv_clear.
  - Configuration error: cfg_cache_size or cfg_line_size is zero or not a power of two. The request is rejected, status[3] is set, and a full request still pulses inv_clear.
- FSM states: IDLE, FULL, SMART_RD, SMART_WAIT, SMART_CMP, DONE.
- IDLE → FULL on an accepted full request. The index counter is cleared and status[1], [2], [3] and [31:16] are cleared.
- FULL: each cycle drives tag_en=1, tag_we=1, tag_idx=counter. It then increments the counter and the invalidated-line count. After index cfg_cache_size-1 it goes to DONE.
- IDLE → SMART_RD on an accepted smart request. It latches line = cfg_smart_addr >> log2(cfg_line_size) and idx = line & (cfg_cache_size-1), truncated to IDX_W. It clears the same status bits as a full request.
- SMART_RD: drives tag_en=1, tag_we=0, tag_idx=idx. Next state is SMART_WAIT.
- SMART_WAIT: samples tag_rvalid and tag_rtag. Next state is SMART_CMP.
- SMART_CMP:
  - Hit (valid and tag equals line): drives tag_en=1, tag_we=1, tag_idx=idx, sets status[2] and sets the count to 1.
  - Miss: no write.
  - Next state is DONE.
- DONE: sets status[1] (done, sticky). Next state is IDLE.
- Requests while busy:
  - A full request is held in a single pending flag and starts on the cycle after DONE.
  - A smart request while busy is dropped and sets status[4] (sticky). status[4] clears only on reset.
- Same-cycle full and smart request: the full request wins and the smart request is discarded without setting status[4].
- status layout: [0] busy, [1] done, [2] smart hit, [3] cfg error, [4] smart dropped, [15:5] 0, [31:16] invalidated-line count. The count saturates at 0xFFFF.
- log2 is a priority encoder over the 10-bit field.

## Timing
- Reset values: inv_clear=0, tag_en=0, tag_we=0, tag_idx=0, status=0, busy=0. The FSM goes to IDLE and the pending flag is cleared.
- Reset asserted mid-operation aborts the walk immediately. A partially invalidated array is acceptable.
- inv_clear pulses in the cycle after cfg_invalidate's rising edge is sampled, whether the request is accepted, rejected, or pending.
- busy rises the cycle after the request is sampled and falls the cycle after DONE.
- Full walk: cfg_cache_size tag writes on consecutive cycles; busy is high for cfg_cache_size+1 cycles.
- Smart: busy is high for exactly 4 cycles (RD, WAIT, CMP, DONE). The clearing write happens in CMP.
- Configuration fields are sampled at request acceptance. Changes during an operation do not affect it.

## Configuration
- CACHE_INV_SMART_EN defined: the smart path and states SMART_RD/WAIT/CMP are present.
- CACHE_INV_SMART_EN undefined:
  - cfg_smart_wr, tag_rvalid and tag_rtag are ignored.
  - status[2] and status[4] are tied to 0.
  - The FSM is reduced to IDLE, FULL, DONE.

## Test plan
- Full walk: cache_size=8, line_size=16, pulse invalidate → inv_clear one pulse; tag writes to idx 0..7 on 8 consecutive cycles; then status=0x0008_0002.
- Smart hit: line_size=64, cache_size=256, write addr 0x1000_0840 with the tag model holding valid=1, tag 0x0040_0021 at idx 0x21 → one write at idx 0x21; status=0x0001_0006.
- Smart miss: same setup with stored tag 0x0040_0121 → no write; status=0x0000_0002.
- Error: cache_size=12 with invalidate → inv_clear pulses, no tag access, status=0x0000_0008.
- Overlap: during a full walk of 4 lines, raise a smart write and a second invalidate edge → status[4]=1; a second walk starts on the cycle after the first DONE.
- Reset mid-walk (aresetn low at index 3 of 8) → all outputs 0 the next cycle; no further tag writes.

Source files
------------

// File: rtl/cache_inv_ctrl.sv
// Cache invalidation sequencer: full-array walk or single-line smart invalidate, plus STATUS_REG_CACHE.
// Define CACHE_INV_SMART_EN to build the smart (single-line) invalidate path.
module cache_inv_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 10
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cfg_enable,
  input  logic [9:0]        cfg_cache_size,
  input  logic [9:0]        cfg_line_size,
  input  logic              cfg_invalidate,
  input  logic [ADDR_W-1:0] cfg_smart_addr,
  input  logic              cfg_smart_wr,
  output logic              inv_clear,
  output logic              tag_en,
  output logic              tag_we,
  output logic [IDX_W-1:0]  tag_idx,
  input  logic              tag_rvalid,
  input  logic [ADDR_W-1:0] tag_rtag,
  output logic [31:0]       status,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, FULL, DONE
`ifdef CACHE_INV_SMART_EN
    , SMART_RD, SMART_WAIT, SMART_CMP
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              inv_q, inv_clear_q, inv_clear_d;
  logic              pend_q, pend_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d, last_q, last_d;
  logic              done_q, done_d, hit_q, hit_d, err_q, err_d, drop_q, drop_d;
  logic [15:0]       lines_q, lines_d;
  logic              full_req, smart_req, cfg_err, take_full;

  function automatic logic bad_field(input logic [9:0] v);
    return (v == '0) || ((v & (v - 10'd1)) != '0);
  endfunction

  assign full_req = cfg_invalidate & ~inv_q;
  assign cfg_err  = bad_field(cfg_cache_size) | bad_field(cfg_line_size);

`ifdef CACHE_INV_SMART_EN
  logic [ADDR_W-1:0] line_q, line_d, smart_line;
  logic [IDX_W-1:0]  sidx_q, sidx_d, smart_idx;
  logic              rhit_q, rhit_d;
  logic [3:0]        line_sh;

  // Full request takes priority; a simultaneous smart write is discarded silently.
  assign smart_req = cfg_smart_wr & ~full_req;

  always_comb begin
    line_sh = '0;
    for (int unsigned i = 0; i < 10; i++)
      if (cfg_line_size[i]) line_sh = 4'(i);
  end

  assign smart_line = cfg_smart_addr >> line_sh;
  assign smart_idx  = smart_line[IDX_W-1:0] & IDX_W'(cfg_cache_size - 10'd1);
`else
  logic unused_smart;
  assign smart_req    = 1'b0;
  assign unused_smart = ^{cfg_smart_wr, cfg_smart_addr, tag_rvalid, tag_rtag};
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      inv_q       <= 1'b0;
      inv_clear_q <= 1'b0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      last_q      <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      lines_q     <= '0;
`ifdef CACHE_INV_SMART_EN
      line_q      <= '0;
      sidx_q      <= '0;
      rhit_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      inv_q       <= cfg_invalidate;
      inv_clear_q <= inv_clear_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      lines_q     <= lines_d;
`ifdef CACHE_INV_SMART_EN
      line_q      <= line_d;
      sidx_q      <= sidx_d;
      rhit_q      <= rhit_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    inv_clear_d = full_req;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    done_d      = done_q;
    hit_d       = hit_q;
    err_d       = err_q;
    drop_d      = drop_q;
    lines_d     = lines_q;
    take_full   = 1'b0;
`ifdef CACHE_INV_SMART_EN
    line_d      = line_q;
    sidx_d      = sidx_q;
    rhit_d      = rhit_q;
`endif
    case (state_q)
      IDLE: take_full = full_req;
      FULL: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (lines_q != 16'hFFFF) lines_d = lines_q + 16'd1;
        if (cnt_q == last_q) state_d = DONE;
      end
`ifdef CACHE_INV_SMART_EN
      SMART_RD:   state_d = SMART_WAIT;
      SMART_WAIT: begin
        rhit_d  = tag_rvalid && (tag_rtag == line_q);
        state_d = SMART_CMP;
      end
      SMART_CMP: begin
        if (rhit_q) begin
          hit_d   = 1'b1;
          lines_d = 16'd1;
        end
        state_d = DONE;
      end
`endif
      DONE: begin
        // A held full request launches straight out of DONE, with acceptance checks re-applied.
        done_d    = 1'b1;
        state_d   = IDLE;
        take_full = pend_q | full_req;
        pend_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && state_q != DONE && full_req) pend_d = 1'b1;
    if (state_q != IDLE && smart_req) drop_d = 1'b1;

    if (take_full) begin
      if (cfg_enable) begin
        if (cfg_err) begin
          err_d = 1'b1;
        end else begin
          state_d = FULL;
          cnt_d   = '0;
          last_d  = IDX_W'(cfg_cache_size - 10'd1);
          done_d  = 1'b0;
          hit_d   = 1'b0;
          err_d   = 1'b0;
          lines_d = '0;
        end
      end
    end
`ifdef CACHE_INV_SMART_EN
    else if (state_q == IDLE && smart_req && cfg_enable) begin
      if (cfg_err) begin
        err_d = 1'b1;
      end else begin
        state_d = SMART_RD;
        line_d  = smart_line;
        sidx_d  = smart_idx;
        done_d  = 1'b0;
        hit_d   = 1'b0;
        err_d   = 1'b0;
        lines_d = '0;
      end
    end
`endif
  end

  always_comb begin
    tag_en  = 1'b0;
    tag_we  = 1'b0;
    tag_idx = '0;
    case (state_q)
      FULL: begin
        tag_en  = 1'b1;
        tag_we  = 1'b1;
        tag_idx = cnt_q;
      end
`ifdef CACHE_INV_SMART_EN
      SMART_RD: begin
        tag_en  = 1'b1;
        tag_idx = sidx_q;
      end
      SMART_CMP: begin
        tag_en  = rhit_q;
        tag_we  = rhit_q;
        tag_idx = rhit_q ? sidx_q : '0;
      end
`endif
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign inv_clear = inv_clear_q;
  assign status    = {lines_q, 11'b0, drop_q, err_q, hit_q, done_q, busy};

endmodule

// File: tb/tb_cache_inv_ctrl.sv
// Directed bench for cache_inv_ctrl with a tag-array model and a queue of expected tag-write indices.
module tb_cache_inv_ctrl;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 10;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              cfg_enable = 1'b0;
  logic [9:0]        cfg_cache_size = 10'd8;
  logic [9:0]        cfg_line_size = 10'd16;
  logic              cfg_invalidate = 1'b0;
  logic [ADDR_W-1:0] cfg_smart_addr = '0;
  logic              cfg_smart_wr = 1'b0;
  logic              inv_clear, tag_en, tag_we, busy;
  logic [IDX_W-1:0]  tag_idx;
  logic              tag_rvalid = 1'b0;
  logic [ADDR_W-1:0] tag_rtag = '0;
  logic [31:0]       status;

  cache_inv_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_enable(cfg_enable),
    .cfg_cache_size(cfg_cache_size), .cfg_line_size(cfg_line_size),
    .cfg_invalidate(cfg_invalidate), .cfg_smart_addr(cfg_smart_addr),
    .cfg_smart_wr(cfg_smart_wr), .inv_clear(inv_clear), .tag_en(tag_en),
    .tag_we(tag_we), .tag_idx(tag_idx), .tag_rvalid(tag_rvalid),
    .tag_rtag(tag_rtag), .status(status), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;
  int clr_cnt = 0;
  int rd_cnt = 0;
  int n, base_clr, base_rd;
  logic [IDX_W-1:0]  exp_wr[$];
  logic [IDX_W-1:0]  e_idx;
  logic              mem_v [0:1023];
  logic [ADDR_W-1:0] mem_t [0:1023];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge aclk)
    if (tag_en && !tag_we) begin
      tag_rvalid <= mem_v[tag_idx];
      tag_rtag   <= mem_t[tag_idx];
    end

  always @(negedge aclk) begin
    if (inv_clear) clr_cnt++;
    if (tag_en && !tag_we) rd_cnt++;
    if (tag_en && tag_we) begin
      if (exp_wr.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexp_wr: observed write idx %0h expected none", tag_idx);
      end else begin
        e_idx = exp_wr.pop_front();
        check("wr_idx", 32'(tag_idx), 32'(e_idx));
      end
    end
  end

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic do_reset();
    cfg_invalidate = 1'b0;
    cfg_smart_wr   = 1'b0;
    aresetn        = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic run_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_v[i] = 1'b0;
      mem_t[i] = '0;
    end

    // reset state
    tick();
    tick();
    check("rst_status", status, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tag_en", 32'(tag_en), 32'd0);
    check("rst_tag_we", 32'(tag_we), 32'd0);
    check("rst_tag_idx", 32'(tag_idx), 32'd0);
    check("rst_inv_clear", 32'(inv_clear), 32'd0);
    aresetn = 1'b1;
    tick();

    // full walk of 8 lines
    cfg_enable = 1'b1; cfg_cache_size = 10'd8; cfg_line_size = 10'd16;
    base_clr = clr_cnt;
    for (int i = 0; i < 8; i++) exp_wr.push_back(IDX_W'(i));
    cfg_invalidate = 1'b1;
    tick();
    check("fw_inv_clear", 32'(inv_clear), 32'd1);
    check("fw_busy_rise", 32'(busy), 32'd1);
    run_busy(n);
    check("fw_busy_len", 32'(n), 32'd9);
    check("fw_status", status, 32'h0008_0002);
    check("fw_wr_left", 32'(exp_wr.size()), 32'd0);
    check("fw_clr_pulses", 32'(clr_cnt - base_clr), 32'd1);
    cfg_invalidate = 1'b0;
    tick();

    // configuration error: non power-of-two cache size
    do_reset();
    cfg_cache_size = 10'd12;
    base_clr = clr_cnt; base_rd = rd_cnt;
    cfg_invalidate = 1'b1;
    tick();
    check("err_inv_clear", 32'(inv_clear), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    tick();
    tick();
    check("err_status", status, 32'h0000_0008);
    check("err_reads", 32'(rd_cnt - base_rd), 32'd0);
    check("err_clr_pulses", 32'(clr_cnt - base_clr), 32'd1);
    cfg_invalidate = 1'b0; cfg_cache_size = 10'd8;
    tick();

    // request while disabled: ignored, inv_clear still pulses
    cfg_enable = 1'b0;
    cfg_invalidate = 1'b1;
    tick();
    check("dis_inv_clear", 32'(inv_clear), 32'd1);
    check("dis_busy", 32'(busy), 32'd0);
    tick();
    check("dis_status", status, 32'h0000_0008);
    cfg_invalidate = 1'b0; cfg_enable = 1'b1;
    tick();

`ifdef CACHE_INV_SMART_EN
    // smart hit
    do_reset();
    cfg_cache_size = 10'd256; cfg_line_size = 10'd64;
    mem_v[10'h21] = 1'b1; mem_t[10'h21] = 32'h0040_0021;
    exp_wr.push_back(IDX_W'('h21));
    cfg_smart_addr = 32'h1000_0840;
    cfg_smart_wr = 1'b1;
    tick();
    cfg_smart_wr = 1'b0;
    run_busy(n);
    check("sh_busy_len", 32'(n), 32'd4);
    check("sh_status", status, 32'h0001_0006);
    check("sh_wr_left", 32'(exp_wr.size()), 32'd0);

    // smart miss
    mem_t[10'h21] = 32'h0040_0121;
    base_rd = rd_cnt;
    cfg_smart_wr = 1'b1;
    tick();
    cfg_smart_wr = 1'b0;
    run_busy(n);
    check("sm_busy_len", 32'(n), 32'd4);
    check("sm_status", status, 32'h0000_0002);
    check("sm_reads", 32'(rd_cnt - base_rd), 32'd1);
`else
    // smart writes have no effect in this build
    do_reset();
    base_rd = rd_cnt;
    cfg_smart_addr = 32'h1000_0840;
    cfg_smart_wr = 1'b1;
    tick();
    cfg_smart_wr = 1'b0;
    check("ns_busy", 32'(busy), 32'd0);
    tick();
    check("ns_status", status, 32'h0);
    check("ns_reads", 32'(rd_cnt - base_rd), 32'd0);
`endif

    // same-cycle full and smart: full wins, no drop flag
    do_reset();
    cfg_cache_size = 10'd4; cfg_line_size = 10'd16;
    for (int i = 0; i < 4; i++) exp_wr.push_back(IDX_W'(i));
    cfg_invalidate = 1'b1; cfg_smart_wr = 1'b1;
    tick();
    cfg_smart_wr = 1'b0;
    run_busy(n);
    check("sc_busy_len", 32'(n), 32'd5);
    check("sc_status", status, 32'h0004_0002);
    cfg_invalidate = 1'b0;
    tick();

    // overlap: smart drop plus a pending second walk
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) exp_wr.push_back(IDX_W'(i));
    base_clr = clr_cnt;
    cfg_invalidate = 1'b1;
    tick();
    cfg_invalidate = 1'b0; cfg_smart_wr = 1'b1;
    tick();
    cfg_smart_wr = 1'b0; cfg_invalidate = 1'b1;
    tick();
    run_busy(n);
    check("ov_busy_len", 32'(n + 2), 32'd10);
`ifdef CACHE_INV_SMART_EN
    check("ov_status", status, 32'h0004_0012);
`else
    check("ov_status", status, 32'h0004_0002);
`endif
    check("ov_wr_left", 32'(exp_wr.size()), 32'd0);
    check("ov_clr_pulses", 32'(clr_cnt - base_clr), 32'd2);
    cfg_invalidate = 1'b0;
    tick();

    // reset mid-walk at index 3 of 8
    cfg_cache_size = 10'd8;
    for (int i = 0; i < 4; i++) exp_wr.push_back(IDX_W'(i));
    cfg_invalidate = 1'b1;
    tick();
    n = 0;
    while (tag_idx != IDX_W'(3) && n < 50) begin
      n++;
      tick();
    end
    check("rm_reach_idx3", 32'(tag_idx), 32'd3);
    aresetn = 1'b0; cfg_invalidate = 1'b0;
    tick();
    check("rm_status", status, 32'h0);
    check("rm_tag_en", 32'(tag_en), 32'd0);
    check("rm_tag_we", 32'(tag_we), 32'd0);
    check("rm_tag_idx", 32'(tag_idx), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_inv_clear", 32'(inv_clear), 32'd0);
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    tick();
    check("rm_wr_left", 32'(exp_wr.size()), 32'd0);
    check("rm_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
